// File: rtl/mux_pkg.sv
// Shared constants and FSM state type for the round-robin mux select arbiter.
// Used by rr_pick and mux_rr_sel_arbiter.
package mux_pkg;

    localparam int NUM_INP = 31;
    localparam int SEL_W   = 5;
    localparam int DATA_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first-set: first set req bit at index >= ptr, wrapping.
// Ports: req (request vector), ptr (search start), any (some request), idx (pick).
module rr_pick #(
    parameter int NUM_INP = mux_pkg::NUM_INP,
    parameter int SEL_W   = mux_pkg::SEL_W
) (
    input  logic [NUM_INP-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_INP-1:0] dbl;
    logic [NUM_INP-1:0]   rot;
    logic [SEL_W-1:0]     off;
    logic                 hit;
    logic [SEL_W:0]       sum;

    // Doubling the vector turns the wrap-around search into a plain
    // lowest-bit search on a window starting at ptr.
    always_comb begin
        dbl = {req, req};
        rot = NUM_INP'(dbl >> ptr);
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < NUM_INP; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = SEL_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W+1)'(NUM_INP)) begin
            sum = sum - (SEL_W+1)'(NUM_INP);
        end
        any = hit;
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin select sequencer for a 31:1 mux: registers sel, captures the mux
// output one cycle later and offers it on a valid/ready port.
// Ports: clk, reset (async high), req, mux_out in; sel, grant_valid, grant_id,
// data_out, data_valid out; data_ready in.
module mux_rr_sel_arbiter #(
    parameter int NUM_INP = mux_pkg::NUM_INP,
    parameter int SEL_W   = mux_pkg::SEL_W,
    parameter int DATA_W  = mux_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_INP-1:0] req,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   grant_id,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    input  logic               data_ready
);

    import mux_pkg::*;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dv_q, dv_d;

    logic                accept;
    logic [SEL_W-1:0]    sel_inc;
    logic                pick_any;
    logic [SEL_W-1:0]    pick_idx;

    assign accept  = dv_q && data_ready;
    assign sel_inc = (sel_q == SEL_W'(NUM_INP-1)) ? '0 : sel_q + 1'b1;

    // Pointer moves past the served index only on an accepted transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == HOLD && accept) begin
            ptr_d = sel_inc;
        end
    end

    // Searching from ptr_d lets a back-to-back grant already skip the
    // requester that was just served.
    rr_pick #(
        .NUM_INP (NUM_INP),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_d),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        dv_d    = dv_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                data_d  = mux_out;
                dv_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    dv_d = 1'b0;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    assign sel         = sel_q;
    assign grant_id    = sel_q;
    assign grant_valid = (state_q != IDLE);
    assign data_out    = data_q;
    assign data_valid  = dv_q;

endmodule
